// File: rtl/demux_tdm_pkg.sv
// demux_tdm_pkg: shared types and constants for the TDM nibble demultiplexer.
// Optional feature macro: DEMUX_TDM_CHKSUM_EN adds a fifth XOR-checksum slot
// to every frame and widens the slot index to 3 bits.
package demux_tdm_pkg;

    // Receiver states: waiting for start, collecting slots, publishing a frame.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Number of data channels carried in every frame.
    localparam int NUM_CH = 4;

`ifdef DEMUX_TDM_CHKSUM_EN
    // Four data slots followed by one checksum slot.
    localparam int NUM_SLOTS = 5;
    localparam int SLOT_W    = 3;
`else
    // Four data slots, no checksum.
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
`endif

    // Index of a slot within a frame.
    typedef logic [SLOT_W-1:0] slot_idx_t;

    localparam slot_idx_t SLOT_ZERO = slot_idx_t'(0);
    localparam slot_idx_t SLOT_ONE  = slot_idx_t'(1);
    localparam slot_idx_t LAST_SLOT = slot_idx_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/demux_tdm_idle_timer.sv
// demux_tdm_idle_timer: counts idle cycles down from TIMEOUT while a frame is
// being received. clear_i reloads the counter, tick_i consumes one idle cycle,
// and expire_o flags the tick that exhausts the budget. With TIMEOUT=0 the
// counter is not built and expire_o is held low.
module demux_tdm_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic tick_i,
    output logic expire_o
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
            localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Next count: reload on clear, step down on an idle tick, else hold.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = CNT_LOAD;
                end else if (tick_i && (cnt_q != CNT_ZERO)) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end

            // Counter register; reset leaves a full idle budget loaded.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= CNT_LOAD;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // The tick that sees one remaining idle cycle is the expiring one.
            assign expire_o = tick_i && !clear_i && (cnt_q == CNT_ONE);
        end else begin : g_tieoff
            logic unused_s;
            assign unused_s = clk ^ rst_n ^ clear_i ^ tick_i;
            assign expire_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/demux_tdm_b4.sv
// demux_tdm_b4: time-division demultiplexer for a 4-slot nibble frame.
// Slots arrive on din qualified by din_vld after a start strobe; slot k is
// staged in shadow[k] and all four output channels are loaded together in the
// COMMIT cycle that follows acceptance of the last slot. Partial or aborted
// frames never disturb o0..o3.
// Optional feature macro: DEMUX_TDM_CHKSUM_EN (fifth slot = XOR of slots 0..3;
// a mismatch aborts the frame with an err pulse instead of committing).
module demux_tdm_b4
    import demux_tdm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output slot_idx_t        s,
    output logic             busy,
    output logic             frame_vld,
    output logic             err
);

    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    // XOR fold of the four staged data slots, used as the frame checksum.
    function automatic logic [WIDTH-1:0] xor_fold(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] d
    );
        return a ^ b ^ c ^ d;
    endfunction

    state_e           state_q;
    slot_idx_t        s_q;
    slot_idx_t        s_inc_d;
    logic             busy_q;
    logic             frame_vld_q;
    logic             err_q;
    logic [WIDTH-1:0] shadow_q [NUM_CH];
    logic [WIDTH-1:0] out_q    [NUM_CH];

    logic [1:0]       wr_idx_s;
    logic             last_slot_s;
    logic             chk_slot_s;
    logic             chk_ok_s;
    logic             tmr_clear_s;
    logic             tmr_tick_s;
    logic             tmr_expire_s;

    // Slot bookkeeping: where the next data slot lands and whether the
    // current slot closes the frame (and, with a checksum, whether it matches).
    always_comb begin
        wr_idx_s    = s_q[1:0];
        last_slot_s = (s_q == LAST_SLOT);
        s_inc_d     = s_q + SLOT_ONE;
`ifdef DEMUX_TDM_CHKSUM_EN
        chk_slot_s  = last_slot_s;
        chk_ok_s    = (din == xor_fold(shadow_q[0], shadow_q[1],
                                       shadow_q[2], shadow_q[3]));
`else
        chk_slot_s  = 1'b0;
        chk_ok_s    = 1'b1;
`endif
    end

    // Idle timer control: only plain non-valid RECV cycles consume budget;
    // leaving RECV, a restart or any accepted slot refills it.
    always_comb begin
        tmr_clear_s = (state_q != ST_RECV) || start || din_vld;
        tmr_tick_s  = (state_q == ST_RECV) && !start && !din_vld;
    end

    demux_tdm_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmr_clear_s),
        .tick_i   (tmr_tick_s),
        .expire_o (tmr_expire_s)
    );

    // Frame FSM with registered outputs, staging registers and channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= SLOT_ZERO;
            busy_q      <= 1'b0;
            frame_vld_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= DATA_ZERO;
                out_q[i]    <= DATA_ZERO;
            end
        end else begin
            frame_vld_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // New frame; a slot on the same cycle is slot 0.
                        state_q <= ST_RECV;
                        busy_q  <= 1'b1;
                        s_q     <= din_vld ? SLOT_ONE : SLOT_ZERO;
                        if (din_vld) begin
                            shadow_q[0] <= din;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        s_q     <= SLOT_ZERO;
                    end
                end

                ST_RECV: begin
                    if (start) begin
                        // Silent restart: drop the partial frame, begin anew.
                        state_q <= ST_RECV;
                        busy_q  <= 1'b1;
                        s_q     <= din_vld ? SLOT_ONE : SLOT_ZERO;
                        if (din_vld) begin
                            shadow_q[0] <= din;
                        end
                    end else if (din_vld) begin
                        if (!chk_slot_s) begin
                            shadow_q[wr_idx_s] <= din;
                        end
                        if (last_slot_s) begin
                            s_q <= SLOT_ZERO;
                            if (chk_ok_s) begin
                                state_q <= ST_COMMIT;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            s_q <= s_inc_d;
                        end
                    end else if (tmr_expire_s) begin
                        // Link went quiet for too long: abandon the frame.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        s_q     <= SLOT_ZERO;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_RECV;
                    end
                end

                ST_COMMIT: begin
                    // Publish all channels at once; shadow reads see old data
                    // even if slot 0 of the next frame is captured now.
                    for (int i = 0; i < NUM_CH; i++) begin
                        out_q[i] <= shadow_q[i];
                    end
                    frame_vld_q <= 1'b1;
                    if (start) begin
                        state_q <= ST_RECV;
                        busy_q  <= 1'b1;
                        s_q     <= din_vld ? SLOT_ONE : SLOT_ZERO;
                        if (din_vld) begin
                            shadow_q[0] <= din;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        s_q     <= SLOT_ZERO;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    s_q     <= SLOT_ZERO;
                end
            endcase
        end
    end

    assign o0        = out_q[0];
    assign o1        = out_q[1];
    assign o2        = out_q[2];
    assign o3        = out_q[3];
    assign s         = s_q;
    assign busy      = busy_q;
    assign frame_vld = frame_vld_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux_tdm_b4.sv
// tb_demux_tdm_b4: directed scenarios plus a randomized run checked against a
// frame-level reference model (slot list, idle count, pending commit).
module tb_demux_tdm_b4;

`ifdef DEMUX_TDM_CHKSUM_EN
    localparam int NS = 5;
    localparam int SW = 3;
`else
    localparam int NS = 4;
    localparam int SW = 2;
`endif
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    din;
    logic          din_vld;
    logic [3:0]    o0, o1, o2, o3;
    logic [SW-1:0] s;
    logic          busy, frame_vld, err;

    int checks;
    int failures;

    // Reference model state
    int m_o [4];
    int m_buf [5];
    int m_cnt;
    int m_idle;
    bit m_busy;
    bit m_commit;
    bit m_fv;
    bit m_err;

    demux_tdm_b4 #(.WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .din_vld   (din_vld),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .s         (s),
        .busy      (busy),
        .frame_vld (frame_vld),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_o[i] = 0;
        for (int i = 0; i < 5; i++) m_buf[i] = 0;
        m_cnt = 0; m_idle = 0; m_busy = 0; m_commit = 0; m_fv = 0; m_err = 0;
    endtask

    task automatic model_begin(input bit v, input int d);
        m_busy = 1; m_idle = 0;
        if (v) begin m_buf[0] = d; m_cnt = 1; end
        else m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit v, input int d);
        m_fv = 0; m_err = 0;
        if (m_commit) begin
            for (int i = 0; i < 4; i++) m_o[i] = m_buf[i];
            m_fv = 1; m_commit = 0; m_busy = 0; m_cnt = 0;
            if (st) model_begin(v, d);
        end else if (st) begin
            model_begin(v, d);
        end else if (m_busy) begin
            if (v) begin
                m_buf[m_cnt] = d; m_idle = 0;
                if (m_cnt == NS - 1) begin
                    m_cnt = 0;
                    if (NS == 5 && ((m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3]) != d)) begin
                        m_busy = 0; m_err = 1;
                    end else begin
                        m_commit = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end else begin
                m_idle++;
                if (TIMEOUT > 0 && m_idle >= TIMEOUT) begin
                    m_busy = 0; m_err = 1; m_cnt = 0; m_idle = 0;
                end
            end
        end
    endtask

    // One clock with the given inputs; outputs are settled at return.
    task automatic drive(input bit st, input bit v, input logic [3:0] d);
        start = st; din_vld = v; din = d;
        @(posedge clk);
        #1;
        model_step(st, v, int'(d));
        start = 1'b0; din_vld = 1'b0; din = 4'd0;
    endtask

    task automatic apply_reset();
        start = 1'b0; din_vld = 1'b0; din = 4'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Start strobe followed by four back-to-back data slots (+ checksum).
    task automatic send_frame(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, a);
        drive(1'b0, 1'b1, b);
        drive(1'b0, 1'b1, c);
        drive(1'b0, 1'b1, d);
`ifdef DEMUX_TDM_CHKSUM_EN
        drive(1'b0, 1'b1, a ^ b ^ c ^ d);
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({o0, o1, o2, o3} !== 16'h0000 || s !== '0 || busy !== 1'b0 ||
            frame_vld !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset: o=%h s=%0d busy=%b fv=%b err=%b, expected all zero",
                     {o0, o1, o2, o3}, s, busy, frame_vld, err);
        end
    endtask

    task automatic test_basic();
        send_frame(4'd1, 4'd2, 4'd3, 4'd4);
        checks++;
        if (frame_vld !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_pre: fv=%b busy=%b, expected fv=0 busy=1", frame_vld, busy);
        end
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if ({o0, o1, o2, o3} !== 16'h1234 || frame_vld !== 1'b1 || busy !== 1'b0 || s !== '0) begin
            failures++;
            $display("FAIL basic_commit: o=%h fv=%b busy=%b s=%0d, expected o=1234 fv=1 busy=0 s=0",
                     {o0, o1, o2, o3}, frame_vld, busy, s);
        end
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if (frame_vld !== 1'b0 || {o0, o1, o2, o3} !== 16'h1234) begin
            failures++;
            $display("FAIL basic_hold: fv=%b o=%h, expected fv=0 o=1234", frame_vld, {o0, o1, o2, o3});
        end
    endtask

    task automatic test_gapped();
        logic [3:0] v [4];
        int errs;
        errs = 0;
        for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(0, 15));
        drive(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < NS; i++) begin
            repeat (3) begin
                drive(1'b0, 1'b0, 4'd0);
                if (err !== 1'b0) errs++;
            end
            if (i < 4) drive(1'b0, 1'b1, v[i]);
            else drive(1'b0, 1'b1, v[0] ^ v[1] ^ v[2] ^ v[3]);
            if (err !== 1'b0) errs++;
        end
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if ({o0, o1, o2, o3} !== {v[0], v[1], v[2], v[3]} || frame_vld !== 1'b1 || errs != 0) begin
            failures++;
            $display("FAIL gapped: o=%h fv=%b err_pulses=%0d, expected o=%h fv=1 err_pulses=0",
                     {o0, o1, o2, o3}, frame_vld, errs, {v[0], v[1], v[2], v[3]});
        end
    endtask

    task automatic test_timeout();
        logic [15:0] prev;
        prev = {o0, o1, o2, o3};
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 4'd5);
        drive(1'b0, 1'b1, 4'd6);
        repeat (TIMEOUT - 1) drive(1'b0, 1'b0, 4'd0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: err=%b busy=%b, expected err=0 busy=1", err, busy);
        end
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || {o0, o1, o2, o3} !== prev || frame_vld !== 1'b0) begin
            failures++;
            $display("FAIL timeout: err=%b busy=%b fv=%b o=%h, expected err=1 busy=0 fv=0 o=%h",
                     err, busy, frame_vld, {o0, o1, o2, o3}, prev);
        end
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if (err !== 1'b0 || s !== '0) begin
            failures++;
            $display("FAIL timeout_pulse: err=%b s=%0d, expected err=0 s=0", err, s);
        end
    endtask

    task automatic test_restart();
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 4'd7);
        drive(1'b0, 1'b1, 4'd8);
        drive(1'b1, 1'b1, 4'd9);
        checks++;
        if (s !== SW'(1) || err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_slot0: s=%0d err=%b busy=%b, expected s=1 err=0 busy=1", s, err, busy);
        end
        drive(1'b0, 1'b1, 4'hA);
        drive(1'b0, 1'b1, 4'hB);
        drive(1'b0, 1'b1, 4'hC);
`ifdef DEMUX_TDM_CHKSUM_EN
        drive(1'b0, 1'b1, 4'h9 ^ 4'hA ^ 4'hB ^ 4'hC);
`endif
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if ({o0, o1, o2, o3} !== 16'h9ABC || frame_vld !== 1'b1) begin
            failures++;
            $display("FAIL restart: o=%h fv=%b, expected o=9abc fv=1", {o0, o1, o2, o3}, frame_vld);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 4'd3);
        drive(1'b0, 1'b1, 4'd4);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o0, o1, o2, o3} !== 16'h0000 || s !== '0 || busy !== 1'b0 ||
            frame_vld !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: o=%h s=%0d busy=%b fv=%b err=%b, expected all zero",
                     {o0, o1, o2, o3}, s, busy, frame_vld, err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(4'd1, 4'd2, 4'd3, 4'd4);
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if ({o0, o1, o2, o3} !== 16'h1234 || frame_vld !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_frame: o=%h fv=%b, expected o=1234 fv=1", {o0, o1, o2, o3}, frame_vld);
        end
    endtask

`ifdef DEMUX_TDM_CHKSUM_EN
    task automatic test_chksum();
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 4'd1);
        drive(1'b0, 1'b1, 4'd2);
        drive(1'b0, 1'b1, 4'd4);
        drive(1'b0, 1'b1, 4'd8);
        drive(1'b0, 1'b1, 4'hF);
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if ({o0, o1, o2, o3} !== 16'h1248 || frame_vld !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL chksum_ok: o=%h fv=%b err=%b, expected o=1248 fv=1 err=0",
                     {o0, o1, o2, o3}, frame_vld, err);
        end
        send_frame(4'd5, 4'd5, 4'd5, 4'd5);
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 4'd1);
        drive(1'b0, 1'b1, 4'd2);
        drive(1'b0, 1'b1, 4'd4);
        drive(1'b0, 1'b1, 4'd8);
        drive(1'b0, 1'b1, 4'hE);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || {o0, o1, o2, o3} !== 16'h5555) begin
            failures++;
            $display("FAIL chksum_bad: err=%b busy=%b o=%h, expected err=1 busy=0 o=5555",
                     err, busy, {o0, o1, o2, o3});
        end
        drive(1'b0, 1'b0, 4'd0);
        checks++;
        if (frame_vld !== 1'b0 || {o0, o1, o2, o3} !== 16'h5555) begin
            failures++;
            $display("FAIL chksum_nocommit: fv=%b o=%h, expected fv=0 o=5555", frame_vld, {o0, o1, o2, o3});
        end
    endtask
`endif

    task automatic test_random();
        int quiet;
        bit st, v;
        logic [3:0] d;
        quiet = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (quiet > 0) begin
                quiet--; st = 1'b0; v = 1'b0;
            end else begin
                if ($urandom_range(0, 60) == 0) quiet = $urandom_range(10, 20);
                st = ($urandom_range(0, 24) == 0);
                v  = ($urandom_range(0, 9) < 7);
            end
            d = 4'($urandom_range(0, 15));
            drive(st, v, d);
            checks++;
            if (o0 !== 4'(m_o[0]) || o1 !== 4'(m_o[1]) || o2 !== 4'(m_o[2]) || o3 !== 4'(m_o[3]) ||
                s !== SW'(m_cnt) || busy !== m_busy || frame_vld !== m_fv || err !== m_err) begin
                failures++;
                $display("FAIL random cyc=%0d: o=%h s=%0d busy=%b fv=%b err=%b, expected o=%h%h%h%h s=%0d busy=%b fv=%b err=%b",
                         cyc, {o0, o1, o2, o3}, s, busy, frame_vld, err,
                         4'(m_o[0]), 4'(m_o[1]), 4'(m_o[2]), 4'(m_o[3]), m_cnt, m_busy, m_fv, m_err);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        start = 1'b0;
        din_vld = 1'b0;
        din = 4'd0;
        #1;
        test_reset();
        test_basic();
        test_gapped();
        test_timeout();
        test_restart();
        test_async_reset();
`ifdef DEMUX_TDM_CHKSUM_EN
        test_chksum();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
